// File: rtl/vga_addr_gen.sv
// VGA beam-to-framebuffer address generator: a 3-stage pipeline for scaling, rotation, clamping,
// window test and linear RAM address. It also latches the rotation mode at each frame start and counts frames.
module vga_addr_gen #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_SHIFT = 1,
    parameter int XMAX        = 240,
    parameter int YMAX        = 320,
    parameter int YOFFSET     = 24,
    parameter int WIN_H       = 264,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic [1:0]        mode,
    output logic [9:0]        xpos,
    output logic [9:0]        ypos,
    output logic              in_win,
    output logic              active,
    output logic [ADDR_W-1:0] address,
    output logic              frame_start,
    output logic [7:0]        frame_cnt
);

    localparam int P_W = (ADDR_W > 20) ? ADDR_W : 20;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [9:0]        H_ACT_C  = 10'(H_ACTIVE);
    localparam logic [9:0]        V_ACT_C  = 10'(V_ACTIVE);
    localparam logic signed [11:0] XM1_C   = 12'(XMAX - 1);
    localparam logic signed [11:0] YM1_C   = 12'(YMAX - 1);
    localparam logic [9:0]        YOFF_C   = 10'(YOFFSET);
    localparam logic [9:0]        YEND_C   = 10'(YOFFSET + WIN_H);
    localparam logic [P_W-1:0]    WIN_H_C  = P_W'(WIN_H);

    typedef enum logic [1:0] {ROT_0, ROT_90, ROT_180, ROT_270} rot_e;

    logic w_origin;
    rot_e w_mode_eff;
    rot_e r_mode;

    // The origin pixel takes the new mode itself, so a change at hc=0,vc=0 applies to that same pixel.
    assign w_origin   = (hc == 10'd0) && (vc == 10'd0);
    assign w_mode_eff = w_origin ? rot_e'(mode) : r_mode;

    // ---------------- stage 1: scale and activity ----------------
    logic [9:0] r1_sx, r1_sy;
    logic       r1_act, r1_fs;
    rot_e       r1_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode  <= ROT_90;
            r1_sx   <= '0;
            r1_sy   <= '0;
            r1_act  <= 1'b0;
            r1_fs   <= 1'b0;
            r1_mode <= ROT_90;
        end else if (pix_en) begin
            // NOTE: non-blocking assignments keep every stage reading the previous-cycle value of its neighbour.
            r1_sx   <= hc >> SCALE_SHIFT;
            r1_sy   <= vc >> SCALE_SHIFT;
            r1_act  <= (hc < H_ACT_C) && (vc < V_ACT_C);
            r1_fs   <= w_origin;
            r1_mode <= w_mode_eff;
            if (w_origin) r_mode <= rot_e'(mode);
        end
    end

    // ---------------- stage 2: rotate, clamp, window, multiply ----------------
    logic signed [11:0] w_xm, w_ym;
    logic [9:0]         w_x, w_y;
    logic               w_clip, w_win;

    always_comb begin
        // NOTE: defaulting every output first keeps the case from inferring latches.
        w_xm = '0;
        w_ym = '0;
        case (r1_mode)
            ROT_0: begin
                w_xm = $signed({2'b00, r1_sx});
                w_ym = $signed({2'b00, r1_sy});
            end
            ROT_90: begin
                w_xm = XM1_C - $signed({2'b00, r1_sy});
                w_ym = $signed({2'b00, r1_sx});
            end
            ROT_180: begin
                w_xm = XM1_C - $signed({2'b00, r1_sx});
                w_ym = YM1_C - $signed({2'b00, r1_sy});
            end
            ROT_270: begin
                w_xm = $signed({2'b00, r1_sy});
                w_ym = YM1_C - $signed({2'b00, r1_sx});
            end
            default: ;
        endcase
    end

    always_comb begin
        w_x    = w_xm[9:0];
        w_y    = w_ym[9:0];
        w_clip = 1'b0;
        if (w_xm < 12'sd0) begin
            w_x    = '0;
            w_clip = 1'b1;
        end else if (w_xm > XM1_C) begin
            w_x    = XM1_C[9:0];
            w_clip = 1'b1;
        end
        if (w_ym < 12'sd0) begin
            w_y    = '0;
            w_clip = 1'b1;
        end else if (w_ym > YM1_C) begin
            w_y    = YM1_C[9:0];
            w_clip = 1'b1;
        end
        if (!r1_act) begin
            w_x = '0;
            w_y = '0;
        end
        w_win = r1_act && !w_clip && (w_y >= YOFF_C) && (w_y < YEND_C);
    end

    logic [9:0]     r2_x, r2_y;
    logic           r2_win, r2_act, r2_fs;
    logic [P_W-1:0] r2_p;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r2_x   <= '0;
            r2_y   <= '0;
            r2_win <= 1'b0;
            r2_act <= 1'b0;
            r2_fs  <= 1'b0;
            r2_p   <= '0;
        end else if (pix_en) begin
            r2_x   <= w_x;
            r2_y   <= w_y;
            r2_win <= w_win;
            r2_act <= r1_act;
            r2_fs  <= r1_fs;
            r2_p   <= P_W'(w_x) * WIN_H_C;
        end
    end

    // ---------------- stage 3: address and frame bookkeeping ----------------
    logic [9:0]        r_xpos, r_ypos;
    logic              r_in_win, r_active, r_frame_start;
    logic [ADDR_W-1:0] r_address;
    logic [7:0]        r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xpos        <= '0;
            r_ypos        <= '0;
            r_in_win      <= 1'b0;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
            r_address     <= ADDR_MAX;
            r_frame_cnt   <= '0;
        end else if (pix_en) begin
            r_xpos        <= r2_x;
            r_ypos        <= r2_y;
            r_in_win      <= r2_win;
            r_active      <= r2_act;
            r_frame_start <= r2_fs;
            r_address     <= r2_win ? ADDR_W'(r2_p + P_W'(r2_y - YOFF_C)) : ADDR_MAX;
            if (r2_fs) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign in_win      = r_in_win;
    assign active      = r_active;
    assign address     = r_address;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_addr_gen.sv
// Directed bench for vga_addr_gen: hand-computed coordinates/addresses for each rotation,
// window edges, pix_en stalls, mode latching, reset mid-line and frame counter wrap.
module tb_vga_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  hc, vc;
    logic [1:0]  mode;
    logic [9:0]  xpos, ypos;
    logic        in_win, active, frame_start;
    logic [15:0] address;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int cnt_at_256;

    vga_addr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hc          (hc),
        .vc          (vc),
        .mode        (mode),
        .xpos        (xpos),
        .ypos        (ypos),
        .in_win      (in_win),
        .active      (active),
        .address     (address),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int x, input int y, input int w,
                              input int a, input int ad);
        check({tag, "_x"},    32'(xpos),    32'(x));
        check({tag, "_y"},    32'(ypos),    32'(y));
        check({tag, "_win"},  32'(in_win),  32'(w));
        check({tag, "_act"},  32'(active),  32'(a));
        check({tag, "_addr"}, 32'(address), 32'(ad));
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic cyc(input logic en, input int h, input int v, input int m);
        @(negedge clk);
        pix_en = en;
        hc     = 10'(h);
        vc     = 10'(v);
        mode   = 2'(m);
        @(posedge clk);
        #1;
    endtask

    // Push one pixel and two blank fillers so the pixel reaches the outputs.
    task automatic pix(input int h, input int v, input int m);
        cyc(1'b1, h, v, m);
        cyc(1'b1, 700, 10, m);
        cyc(1'b1, 700, 10, m);
    endtask

    task automatic count_pulse();
        if (frame_start) begin
            pulses++;
            if (pulses == 256) cnt_at_256 = int'(frame_cnt);
        end
    endtask

    initial begin
        rst = 1'b0; pix_en = 1'b0; hc = '0; vc = '0; mode = '0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 0, 0, 65535);
        check("reset_fs",  32'(frame_start), 0);
        check("reset_cnt", 32'(frame_cnt),   0);
        rst = 1'b1;

        // Portrait mapping from the reset-latched mode, with latency check.
        cyc(1'b1, 100, 50, 1);
        cyc(1'b1, 700, 10, 1);
        check("t1_lat2_addr", 32'(address), 65535);
        cyc(1'b1, 700, 10, 1);
        expect_out("t1", 214, 50, 1, 1, 56522);

        pix(20, 50, 1);   expect_out("t2_lowrow", 214, 10, 0, 1, 65535);
        pix(700, 10, 1);  expect_out("t2_blank", 0, 0, 0, 0, 65535);
        pix(574, 0, 1);   expect_out("edge_lastrow", 239, 287, 1, 1, 63359);
        pix(576, 0, 1);   expect_out("edge_pastrow", 239, 288, 0, 1, 65535);
        pix(638, 479, 1); expect_out("edge_corner", 0, 319, 0, 1, 65535);
        pix(639, 480, 1); expect_out("edge_vblank", 0, 0, 0, 0, 65535);

        // Stall: outputs and pipeline hold while pix_en is low.
        cyc(1'b1, 100, 50, 1);
        cyc(1'b1, 20, 50, 1);
        cyc(1'b1, 700, 10, 1);
        check("t3_a_x", 32'(xpos), 214);
        cyc(1'b0, 40, 100, 1);
        check("t3_hold1_addr", 32'(address), 56522);
        cyc(1'b0, 40, 100, 1);
        check("t3_hold2_x",    32'(xpos),    214);
        check("t3_hold2_addr", 32'(address), 56522);
        cyc(1'b1, 700, 10, 1);
        check("t3_b_y",   32'(ypos),   10);
        check("t3_b_win", 32'(in_win), 0);
        cyc(1'b1, 700, 10, 1);
        check("t3_c_act", 32'(active), 0);

        // Mode change mid-frame waits for the origin; the origin pixel uses the new mode.
        cyc(1'b1, 300, 200, 0);
        cyc(1'b1, 0, 0, 0);
        cyc(1'b1, 100, 50, 3);
        expect_out("t4_old", 139, 150, 1, 1, 36822);
        check("t4_old_fs", 32'(frame_start), 0);
        cyc(1'b1, 700, 10, 3);
        expect_out("t4_origin", 0, 0, 0, 1, 65535);
        check("t4_origin_fs",  32'(frame_start), 1);
        check("t4_origin_cnt", 32'(frame_cnt),   1);
        cyc(1'b0, 700, 10, 3);
        check("t4_fs_hold",  32'(frame_start), 1);
        check("t4_cnt_hold", 32'(frame_cnt),   1);
        cyc(1'b1, 700, 10, 3);
        expect_out("t4_new", 50, 25, 1, 1, 13201);
        check("t4_new_fs", 32'(frame_start), 0);
        pix(600, 50, 3);  expect_out("m0_clampx", 239, 25, 0, 1, 65535);

        // 180 degrees, including a negative x clamp.
        pix(0, 0, 2);     expect_out("m2_origin", 239, 319, 0, 1, 65535);
        check("m2_cnt", 32'(frame_cnt), 2);
        pix(600, 50, 0);  expect_out("m2_clampneg", 0, 294, 0, 1, 65535);
        pix(100, 100, 0); expect_out("m2_mid", 189, 269, 1, 1, 50141);

        // 270 degrees.
        pix(0, 0, 3);     expect_out("m3_origin", 0, 319, 0, 1, 65535);
        pix(100, 50, 0);  expect_out("m3_mid", 25, 269, 1, 1, 6845);

        // Reset mid-line with a full pipeline.
        cyc(1'b1, 100, 100, 0);
        cyc(1'b1, 200, 100, 0);
        cyc(1'b1, 300, 100, 0);
        check("t6_pre_addr", 32'(address), 13445);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        expect_out("t6_rst", 0, 0, 0, 0, 65535);
        check("t6_rst_cnt", 32'(frame_cnt), 0);
        check("t6_rst_fs",  32'(frame_start), 0);
        cyc(1'b0, 700, 10, 0);
        rst = 1'b1;
        cyc(1'b1, 100, 50, 0);
        cyc(1'b1, 700, 10, 0);
        check("t6_lat2_addr", 32'(address), 65535);
        check("t6_lat2_act",  32'(active),  0);
        cyc(1'b1, 700, 10, 0);
        expect_out("t6_first", 214, 50, 1, 1, 56522);

        // 257 frames: one pulse each, counter wraps through zero to one.
        pulses     = 0;
        cnt_at_256 = -1;
        for (int f = 0; f < 257; f++) begin
            cyc(1'b1, 0, 0, 0);
            count_pulse();
            cyc(1'b1, 700, 10, 0);
            count_pulse();
        end
        cyc(1'b1, 700, 10, 0);
        count_pulse();
        cyc(1'b1, 700, 10, 0);
        count_pulse();
        check("t5_pulses", 32'(pulses),     257);
        check("t5_wrap",   32'(cnt_at_256), 0);
        check("t5_cnt",    32'(frame_cnt),  1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
